// File: rtl/rv_fifo_portable_if.sv
// Ready/valid bundle for rv_fifo_portable: the write side, the read side,
// flush and the registered status outputs. The master modport is the user side;
// the slave modport is the FIFO side.
interface rv_fifo_portable_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
);
    logic             flush;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] input_data;
    logic [CW-1:0]    input_usedw;
    logic             input_almost_full;
    logic             output_valid;
    logic             output_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_almost_empty;

    modport master (
        output flush,
        output input_valid,
        output input_data,
        output output_ready,
        input  input_ready,
        input  input_usedw,
        input  input_almost_full,
        input  output_valid,
        input  output_data,
        input  output_almost_empty
    );

    modport slave (
        input  flush,
        input  input_valid,
        input  input_data,
        input  output_ready,
        output input_ready,
        output input_usedw,
        output input_almost_full,
        output output_valid,
        output output_data,
        output output_almost_empty
    );
endinterface

// File: rtl/rv_fifo_portable.sv
// Single-clock ready/valid FIFO with a registered head entry and a
// DEPTH-1 entry body memory. Every status output is registered from the
// next-state count, so there is no combinational path from any input to
// ready, valid, usedw or the almost flags.
module rv_fifo_portable #(
    parameter int DEPTH               = 16,
    parameter int WIDTH               = 32,
    parameter int ALMOSTFULL_ENTRIES  = 0,
    parameter int ALMOSTEMPTY_ENTRIES = 0,
    parameter int CW                  = $clog2(DEPTH + 1)
) (
    input  logic                input_clk,
    input  logic                input_rst,
    rv_fifo_portable_if.slave   bus
);

    localparam int BODY = DEPTH - 1;
    localparam int PW   = (BODY > 1) ? $clog2(BODY) : 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOSTFULL_ENTRIES);
    localparam logic [CW-1:0] AE_LVL   = CW'(ALMOSTEMPTY_ENTRIES);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);

    // Parameter sanity, caught at elaboration.
    if (DEPTH < 2) begin : g_chk_depth
        $error("rv_fifo_portable: DEPTH must be at least 2");
    end
    if (ALMOSTFULL_ENTRIES < 0 || ALMOSTFULL_ENTRIES > DEPTH - 1) begin : g_chk_af
        $error("rv_fifo_portable: ALMOSTFULL_ENTRIES out of range");
    end
    if (ALMOSTEMPTY_ENTRIES < 0 || ALMOSTEMPTY_ENTRIES > DEPTH - 1) begin : g_chk_ae
        $error("rv_fifo_portable: ALMOSTEMPTY_ENTRIES out of range");
    end

    logic [WIDTH-1:0] body_mem [BODY];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head_q;
    logic             ready_q;
    logic             valid_q;
    logic             af_q;
    logic             ae_q;

    logic             wr;
    logic             rd;
    logic             body_empty;
    logic             head_from_input;
    logic             head_from_body;
    logic             body_write;
    logic [CW-1:0]    count_next;

    // Pointers wrap by compare-and-clear so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode and routing: the head is fed straight from the input
    // only when it would otherwise be empty after this cycle.
    always_comb begin
        wr              = bus.input_valid & ready_q;
        rd              = valid_q & bus.output_ready;
        body_empty      = (count <= CW'(1));
        head_from_input = wr & ((count == '0) | ((count == CW'(1)) & rd));
        body_write      = wr & ~head_from_input;
        head_from_body  = rd & ~body_empty;
        if (bus.flush) begin
            count_next = '0;
        end else begin
            count_next = count + {{(CW-1){1'b0}}, wr} - {{(CW-1){1'b0}}, rd};
        end
    end

    // Body storage; no reset needed since pointers/count guard every read.
    always_ff @(posedge input_clk) begin
        if (body_write && !bus.flush) begin
            body_mem[wr_ptr] <= bus.input_data;
        end
    end

    // Count, pointers, head and all registered status flags.
    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            head_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != FULL_LVL);
            valid_q <= (count_next != '0);
            af_q    <= (count_next >= AF_LVL);
            ae_q    <= (count_next <= AE_LVL);
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (body_write) begin
                    wr_ptr <= ptr_adv(wr_ptr);
                end
                if (head_from_body) begin
                    head_q <= body_mem[rd_ptr];
                    rd_ptr <= ptr_adv(rd_ptr);
                end else if (head_from_input) begin
                    head_q <= bus.input_data;
                end
            end
        end
    end

    assign bus.input_ready         = ready_q;
    assign bus.output_valid        = valid_q;
    assign bus.input_usedw         = count;
    assign bus.input_almost_full   = af_q;
    assign bus.output_almost_empty = ae_q;
    assign bus.output_data         = head_q;

endmodule

// File: tb/tb_rv_fifo_portable.sv
// Self-checking bench for rv_fifo_portable at DEPTH=5, WIDTH=8,
// ALMOSTFULL_ENTRIES=1, ALMOSTEMPTY_ENTRIES=1.
module tb_rv_fifo_portable;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int AFE   = 1;
    localparam int AEE   = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    rv_fifo_portable_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    rv_fifo_portable #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .ALMOSTFULL_ENTRIES(AFE),
        .ALMOSTEMPTY_ENTRIES(AEE)
    ) dut (
        .input_clk(clk),
        .input_rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             fl;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             e_ready;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic             chk_data;
        logic [CW-1:0]    e_usedw;
        logic             e_af;
        logic             e_ae;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ready, input logic e_valid,
                           input logic [CW-1:0] e_usedw, input logic e_af, input logic e_ae,
                           input logic chk_data, input logic [WIDTH-1:0] e_data);
        chk({tag, " ready"}, 32'(bus.input_ready), 32'(e_ready));
        chk({tag, " valid"}, 32'(bus.output_valid), 32'(e_valid));
        chk({tag, " usedw"}, 32'(bus.input_usedw), 32'(e_usedw));
        chk({tag, " almost_full"}, 32'(bus.input_almost_full), 32'(e_af));
        chk({tag, " almost_empty"}, 32'(bus.output_almost_empty), 32'(e_ae));
        if (chk_data) begin
            chk({tag, " data"}, 32'(bus.output_data), 32'(e_data));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        bus.flush        = fl;
        bus.input_valid  = iv;
        bus.input_data   = id;
        bus.output_ready = ordy;
    endtask

    // Reference model state for the random phase: the FIFO as a plain queue.
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] got_q [$];

    initial begin
        // fl iv id ordy | ready valid data chk usedw af ae
        tbl[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h23, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 1'b1, 8'h21, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 3'd3, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h23, 1'b1, 3'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h24, 1'b1, 3'd1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};

        // Reset: values apply immediately and hold across edges.
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk_all("reset_imm", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        tick();
        chk_all("reset_hold", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00);
        rst = 1'b0;
        tick();
        chk_all("reset_release", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Fill to full, then drain with input_valid held.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid, tbl[i].e_usedw,
                    tbl[i].e_af, tbl[i].e_ae, tbl[i].chk_data, tbl[i].e_data);
        end

        // Bypass at count 1.
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        tick();
        chk_all("bypass_load", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'hAA);
        drive(1'b0, 1'b1, 8'hBB, 1'b1);
        tick();
        chk_all("bypass", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'hBB);

        // Flush at count 3 with a simultaneous write of 0x55.
        drive(1'b0, 1'b1, 8'hC1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'hC2, 1'b0);
        tick();
        chk_all("pre_flush", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'hBB);
        drive(1'b1, 1'b1, 8'h55, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("flush", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk_all("post_flush", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Random streaming of 0..49 against a queue model.
        begin
            int next_word = 0;
            int cyc = 0;
            while (got_q.size() < 50 && cyc < 2000) begin
                logic iv;
                logic ordy;
                logic wr_m;
                logic rd_m;
                int   sz;
                iv   = (next_word < 50) && (($urandom & 1) == 1);
                ordy = (($urandom & 1) == 1);
                wr_m = iv && (mq.size() != DEPTH);
                rd_m = ordy && (mq.size() != 0);
                drive(1'b0, iv, 8'(next_word), ordy);
                if (bus.output_valid && ordy) begin
                    got_q.push_back(bus.output_data);
                end
                tick();
                cyc++;
                if (rd_m) begin
                    void'(mq.pop_front());
                end
                if (wr_m) begin
                    mq.push_back(8'(next_word));
                    next_word++;
                end
                sz = mq.size();
                chk_all($sformatf("stream c%0d", cyc), sz != DEPTH, sz != 0, CW'(sz),
                        sz >= DEPTH - AFE, sz <= AEE, sz != 0, (sz != 0) ? mq[0] : 8'h00);
            end
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            chk("stream word count", 32'(got_q.size()), 32'd50);
            for (int i = 0; i < got_q.size(); i++) begin
                chk($sformatf("stream order %0d", i), 32'(got_q[i]), 32'(i));
            end
        end

        // Asynchronous reset mid-stream at count 4.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'hA1 + i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("pre_async", 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 8'hA1);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00);
        #2;
        rst = 1'b0;
        tick();
        chk_all("async_release", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("fresh_write", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_fifo_portable.md
Name: rv_fifo_portable

Overview:
- Vendor-neutral single-clock ready/valid FIFO. Successor to the per-vendor HAL ready/valid FIFO wrappers.
- Generalised over the previous generation:
  - any DEPTH ≥ 2, no power-of-2 restriction;
  - exact programmable almost-full and almost-empty, with no threshold fudging;
  - synchronous flush.
- No combinational path from any input to input_ready, output_valid, input_usedw or the almost flags. Used on timing-critical links between generated pipelines.

Parameters:
- DEPTH, 16: total capacity in entries, including the head register. Must be ≥ 2; any integer allowed.
- WIDTH, 32: data width in bits.
- ALMOSTFULL_ENTRIES, 0: input_almost_full asserts when count ≥ DEPTH − ALMOSTFULL_ENTRIES. Range 0..DEPTH−1.
- ALMOSTEMPTY_ENTRIES, 0: output_almost_empty asserts when count ≤ ALMOSTEMPTY_ENTRIES. Range 0..DEPTH−1.
- CW, $clog2(DEPTH+1): width of the count and usedw (derived).

Ports:
- input_clk  in  1  single clock for both sides
- input_rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear, one cycle wide
- input_valid  in  1  write request
- input_ready  out  1  FIFO can accept (registered)
- input_data  in  WIDTH  write data
- input_usedw  out  CW  entries held, registered
- input_almost_full  out  1  registered threshold flag
- output_valid  out  1  head entry valid (registered)
- output_ready  in  1  consumer accepts head
- output_data  out  WIDTH  head entry (registered)
- output_almost_empty  out  1  registered threshold flag

Behaviour:
- Transfer rules:
  - wr = input_valid & input_ready
  - rd = output_valid & output_ready
  - Both sides are standard ready/valid. input_valid may be asserted with ready low; no dependency on ready.
- Storage:
  - A head register drives output_data.
  - A body memory of DEPTH−1 entries with asynchronous read (distributed/regs).
  - wr_ptr and rd_ptr wrap from DEPTH−2 to 0 by compare-and-clear, not modulo-2^n.
- Count update: count_next = count + wr − rd, with all flags registered from count_next:
  - input_ready = (count_next != DEPTH)
  - output_valid = (count_next != 0)
  - input_usedw = count_next
  - input_almost_full = count_next ≥ DEPTH − ALMOSTFULL_ENTRIES
  - output_almost_empty = count_next ≤ ALMOSTEMPTY_ENTRIES
  - Every flag is exact on the cycle after the causing transfer.
- Head/body data movement:
  - wr with no head occupancy (count == 0, or count == 1 with rd): input_data loads the head. output_valid rises the next cycle (latency 1).
  - wr otherwise: the body is written at wr_ptr, then wr_ptr advances.
  - rd with body non-empty: the head loads body[rd_ptr], then rd_ptr advances.
  - rd with body empty and no wr: the head goes invalid.
  - Simultaneous rd and wr at count 1: data bypasses into the head, count stays 1.
- Full: input_ready is 0 at count == DEPTH, even if output_ready is 1 the same cycle. There is no read-through; a write is accepted the following cycle.
- Empty: output_valid is 0. output_data holds its last value and is don't-care.
- Flush:
  - Next cycle: count = 0, pointers = 0, output_valid = 0, input_ready = 1, input_usedw = 0, input_almost_full = 0 (or 1 only if its threshold is ≤ 0, which is excluded), output_almost_empty = 1.
  - Any wr or rd handshake in the flush cycle is discarded. The producer and consumer treat it as complete; the data is lost.
- Reset (asynchronous, applied immediately, mid-operation included):
  - input_ready = 0, output_valid = 0, input_usedw = 0, input_almost_full = 0, output_almost_empty = 1, pointers = 0, output_data = 0.
  - input_ready rises at the first input_clk edge after input_rst deasserts.
- Assertions (sim only):
  - DEPTH ≥ 2;
  - thresholds in range;
  - input_data and input_valid stable while valid & !ready is not required (no check).

Test Plan:
- Fill, DEPTH=5, WIDTH=8, ALMOSTFULL_ENTRIES=1, output_ready=0. Write 0x10..0x14 back-to-back:
  - input_almost_full is 1 the cycle after the 4th write;
  - input_ready is 0 the cycle after the 5th write;
  - input_usedw=5;
  - output_data=0x10, output_valid=1 from the cycle after the 1st write.
- Full with output_ready=1 and input_valid=1 held:
  - reads 0x10..0x14 in order, one per cycle;
  - a new write is accepted only on the cycle after the first read;
  - count never exceeds 5.
- Streaming wrap, DEPTH=5, 50 words 0..49 with input_valid and output_ready both random 50%:
  - output sequence is exactly 0..49;
  - input_usedw always matches the scoreboard count;
  - pointers wrap at 3→0 without loss.
- Bypass at count 1: head=0xAA, simultaneous rd and wr of 0xBB → next cycle output_data=0xBB, output_valid=1, input_usedw=1.
- Flush with count=3 and a simultaneous write of 0x55 → next cycle:
  - output_valid=0, input_usedw=0, output_almost_empty=1, input_ready=1;
  - 0x55 never appears on the output.
- Async reset mid-stream at count=4, pulsed between clock edges:
  - outputs go to reset values immediately, before the next edge;
  - after release, input_ready=1 on the first edge;
  - a fresh write of 0x01 appears on output_data one cycle later.
